bch_error_locate: RTL and testbench



---
 rtl/bch_error_locate_if.sv | 53 +++++
 rtl/bch_error_locate.sv | 227 ++++++++++++++++++++++
 tb/tb_bch_error_locate.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bch_error_locate_if.sv
// ---------------------------------------------------------------------------
// bch_error_locate_if
//   Groups the handshake and data signals of the Chien-search error locator.
//
//   Request side (key-equation solver -> locator):
//     start      sigma/err_count valid; the locator captures them when idle
//     sigma      M*(T+1) locator coefficients, sigma[M*j +: M] = coeff of x^j
//     err_count  error count reported by the key solver
//     busy       search in progress; start is ignored while high
//   Stream side (locator -> correction XOR stage):
//     out_valid  err_out carries a beat
//     out_ready  downstream accepts the beat
//     err_out    1 = bit at the current codeword degree is in error
//     out_last   marks the degree-0 beat
//   Completion:
//     done       one-cycle pulse after the last beat is accepted
//     err_found  roots found in the codeword (valid with done, then held)
//     failed     root count mismatch (valid with done, then held)
//
//   Handshake: a beat transfers on a rising clock edge where out_valid and
//   out_ready are both high; while out_valid is high and out_ready is low,
//   err_out and out_last hold their values.
//
//   Modports: master = solver/consumer side, slave = the locator.
// ---------------------------------------------------------------------------
interface bch_error_locate_if #(
   parameter int M = 4,
   parameter int T = 3
);
   localparam int CW = $clog2(T + 1);

   logic                 start;
   logic [M*(T+1)-1:0]   sigma;
   logic [CW-1:0]        err_count;
   logic                 busy;
   logic                 out_valid;
   logic                 out_ready;
   logic                 err_out;
   logic                 out_last;
   logic                 done;
   logic [CW-1:0]        err_found;
   logic                 failed;

   modport master (
      output start, sigma, err_count, out_ready,
      input  busy, out_valid, err_out, out_last, done, err_found, failed
   );

   modport slave (
      input  start, sigma, err_count, out_ready,
      output busy, out_valid, err_out, out_last, done, err_found, failed
   );
endinterface

// File: rtl/bch_error_locate.sv
// ---------------------------------------------------------------------------
// bch_error_locate
//   Chien-search error locator. Takes the locator polynomial sigma from the
//   key-equation solver, evaluates it at every codeword position and streams
//   one error flag per bit, highest degree first. At the end of each codeword
//   it pulses done together with the root count and a consistency flag.
//
//   Parameters:
//     M  GF(2^M) symbol width
//     T  correction capability (T >= 2)
//     N  codeword length in bits, 1 <= N <= 2^M-1 (shortened codes allowed)
//
//   Ports:
//     clk      clock
//     rst_n    asynchronous active-low reset
//     bus      bch_error_locate_if.slave (start/sigma/err_count/busy,
//              out_valid/out_ready/err_out/out_last, done/err_found/failed)
//     state_o  current FSM state (debug)
//
//   Optional feature, macro BCH_LOCATE_COUNT_CHECK_EN:
//     defined   -> err_count is captured at start and failed reports
//                  err_found != err_count or err_count > T
//     undefined -> failed is tied low and err_count is not stored
// ---------------------------------------------------------------------------
module bch_error_locate #(
   parameter int M = 4,
   parameter int T = 3,
   parameter int N = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   bch_error_locate_if.slave       bus,
   output logic [1:0]              state_o
);
   localparam int CW    = $clog2(T + 1);
   localparam int KW    = $clog2(N + 1);
   localparam int Q     = (1 << M) - 1;  // order of the multiplicative group
   localparam int SHIFT = (1 << M) - N;  // exponent of the first evaluation point

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Low-order terms of a primitive polynomial for GF(2^M) (x^M implied).
   function automatic int prim_poly(input int m);
      case (m)
         2:       return 'h3;
         3:       return 'h3;
         4:       return 'h3;
         5:       return 'h5;
         6:       return 'h3;
         7:       return 'h3;
         8:       return 'h1D;
         9:       return 'h11;
         10:      return 'h9;
         11:      return 'h5;
         12:      return 'h53;
         13:      return 'h1B;
         14:      return 'h443;
         15:      return 'h3;
         default: return 'h100B;
      endcase
   endfunction

   localparam logic [M-1:0] POLY = M'(prim_poly(M));

   function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
      return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY : '0);
   endfunction

   // Shift-and-add multiply; with a constant operand this reduces to XORs.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] r;
      r = '0;
      for (int i = M - 1; i >= 0; i--) begin
         r = gf_xtime(r);
         if (b[i]) r = r ^ a;
      end
      return r;
   endfunction

   // alpha^e by square-and-multiply; only used to build constants.
   function automatic logic [M-1:0] gf_pow(input int e);
      logic [M-1:0] r;
      logic [M-1:0] base;
      r    = M'(1);
      base = M'(2);
      for (int i = 0; i < 31; i++) begin
         if (((e >> i) & 1) != 0) r = gf_mul(r, base);
         base = gf_mul(base, base);
      end
      return r;
   endfunction

   state_t          state_q, state_d;
   logic [M-1:0]    c_q    [0:T];
   logic [M-1:0]    c_d    [0:T];
   logic [M-1:0]    c_load [0:T];
   logic [M-1:0]    c_step [0:T];
   logic [KW-1:0]   k_q, k_d;
   logic [CW-1:0]   root_q, root_d;
   logic [CW-1:0]   err_found_q, err_found_d;
   logic            sum_zero;
   logic            busy, out_valid, err_out, out_last, done;

   // Coefficient j is pre-scaled by alpha^(j*(2^M-N)) at load so that beat 0
   // already evaluates at the first position of a shortened code; each
   // accepted beat then advances term j by alpha^j.
   for (genvar j = 0; j <= T; j++) begin : g_coef
      localparam logic [M-1:0] LOAD_K = gf_pow((j * SHIFT) % Q);
      localparam logic [M-1:0] STEP_K = gf_pow(j % Q);
      assign c_load[j] = gf_mul(bus.sigma[M*j +: M], LOAD_K);
      assign c_step[j] = gf_mul(c_q[j], STEP_K);
   end

   always_comb begin
      logic [M-1:0] acc;
      acc = '0;
      for (int j = 0; j <= T; j++) acc = acc ^ c_q[j];
      sum_zero = (acc == '0);
   end

`ifdef BCH_LOCATE_COUNT_CHECK_EN
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            failed_q, failed_d;
`else
   logic            unused_err_count;
   assign unused_err_count = ^bus.err_count;
`endif

   always_comb begin
      state_d     = state_q;
      c_d         = c_q;
      k_d         = k_q;
      root_d      = root_q;
      err_found_d = err_found_q;
      busy        = 1'b0;
      out_valid   = 1'b0;
      err_out     = 1'b0;
      out_last    = 1'b0;
      done        = 1'b0;
`ifdef BCH_LOCATE_COUNT_CHECK_EN
      cnt_d       = cnt_q;
      failed_d    = failed_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               c_d     = c_load;
               k_d     = '0;
               root_d  = '0;
               state_d = SEARCH;
`ifdef BCH_LOCATE_COUNT_CHECK_EN
               cnt_d   = bus.err_count;
`endif
            end
         end
         SEARCH: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            err_out   = sum_zero;
            out_last  = (k_q == KW'(N - 1));
            if (bus.out_ready) begin
               c_d = c_step;
               if (sum_zero && (root_q != CW'(T))) root_d = root_q + CW'(1);
               if (out_last) begin
                  // Result registers take the count including this last beat
                  // so they are already valid during the done cycle.
                  state_d     = DONE;
                  err_found_d = root_d;
`ifdef BCH_LOCATE_COUNT_CHECK_EN
                  failed_d    = (root_d != cnt_q) || (int'(cnt_q) > T);
`endif
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         for (int j = 0; j <= T; j++) c_q[j] <= '0;
         k_q         <= '0;
         root_q      <= '0;
         err_found_q <= '0;
`ifdef BCH_LOCATE_COUNT_CHECK_EN
         cnt_q       <= '0;
         failed_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         k_q         <= k_d;
         root_q      <= root_d;
         err_found_q <= err_found_d;
`ifdef BCH_LOCATE_COUNT_CHECK_EN
         cnt_q       <= cnt_d;
         failed_q    <= failed_d;
`endif
      end
   end

   assign bus.busy      = busy;
   assign bus.out_valid = out_valid;
   assign bus.err_out   = err_out;
   assign bus.out_last  = out_last;
   assign bus.done      = done;
   assign bus.err_found = err_found_q;
`ifdef BCH_LOCATE_COUNT_CHECK_EN
   assign bus.failed    = failed_q;
`else
   assign bus.failed    = 1'b0;
`endif
   assign state_o       = state_q;

endmodule

// File: tb/tb_bch_error_locate.sv
// ---------------------------------------------------------------------------
// tb_bch_error_locate
//   Bench for bch_error_locate over GF(16) (x^4+x+1), T=3. Instance A uses the
//   full code (N=15), instance B a shortened code (N=10). Expected beats come
//   from evaluating sigma at each codeword position with log/antilog tables.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bch_error_locate;
   localparam int M  = 4;
   localparam int T  = 3;
   localparam int NA = 15;
   localparam int NB = 10;
`ifdef BCH_LOCATE_COUNT_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bch_error_locate_if #(.M(M), .T(T)) bus_a ();
   bch_error_locate_if #(.M(M), .T(T)) bus_b ();
   logic [1:0] unused_state_a, unused_state_b;

   bch_error_locate #(.M(M), .T(T), .N(NA)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a), .state_o(unused_state_a));
   bch_error_locate #(.M(M), .T(T), .N(NB)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b), .state_o(unused_state_b));

   // ---------------- scoreboard state ----------------
   logic [1:0] exp_a_q[$];   // {err_out, out_last}
   logic [1:0] exp_b_q[$];
   logic [2:0] done_a_q[$];  // {err_found, failed}
   logic [2:0] done_b_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int alog[15];
   int lg[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int gmul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return alog[(lg[a] + lg[b]) % 15];
   endfunction

   // Beat k of an n-bit codeword evaluates sigma(alpha^(16-n+k)).
   task automatic push_expect(input bit b, input logic [15:0] sg, input logic [1:0] ec,
                              input int n, output logic [2:0] dexp);
      int roots, e, val, found;
      logic fl;
      logic [1:0] beat;
      roots = 0;
      for (int k = 0; k < n; k++) begin
         e   = 16 - n + k;
         val = 0;
         for (int j = 0; j <= T; j++)
            val = val ^ gmul(int'((sg >> (4 * j)) & 16'hF), alog[(j * e) % 15]);
         if (val == 0) roots++;
         beat = {val == 0, k == n - 1};
         if (b) exp_b_q.push_back(beat); else exp_a_q.push_back(beat);
      end
      found = (roots > T) ? T : roots;
      fl    = CHK ? ((found != int'(ec)) || (int'(ec) > T)) : 1'b0;
      dexp  = {2'(found), fl};
      if (b) done_b_q.push_back(dexp); else done_a_q.push_back(dexp);
   endtask

   // Random locator: either arbitrary coefficients or a product of
   // (1 + alpha^d x) over distinct error degrees d.
   task automatic rand_cw(input int n, output logic [15:0] sg, output logic [1:0] ec);
      int coef[4];
      int used, nerr, d;
      nerr = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
         sg = 16'($urandom);
      end else begin
         coef = '{1, 0, 0, 0};
         used = 0;
         for (int i = 0; i < nerr; i++) begin
            do d = $urandom_range(0, n - 1); while (((used >> d) & 1) != 0);
            used = used | (1 << d);
            for (int j = 3; j >= 1; j--) coef[j] = coef[j] ^ gmul(alog[d], coef[j-1]);
         end
         sg = {4'(coef[3]), 4'(coef[2]), 4'(coef[1]), 4'(coef[0])};
      end
      ec = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(nerr);
   endtask

   // ---------------- DUT access helpers ----------------
   function automatic logic get_valid(input bit b);
      return b ? bus_b.out_valid : bus_a.out_valid;
   endfunction
   function automatic logic get_done(input bit b);
      return b ? bus_b.done : bus_a.done;
   endfunction
   function automatic logic get_busy(input bit b);
      return b ? bus_b.busy : bus_a.busy;
   endfunction
   function automatic logic get_err(input bit b);
      return b ? bus_b.err_out : bus_a.err_out;
   endfunction
   function automatic logic [2:0] get_res(input bit b);
      return b ? {bus_b.err_found, bus_b.failed} : {bus_a.err_found, bus_a.failed};
   endfunction
   function automatic logic [7:0] get_all(input bit b);
      return b ? {bus_b.busy, bus_b.out_valid, bus_b.err_out, bus_b.out_last,
                  bus_b.done, bus_b.err_found, bus_b.failed}
               : {bus_a.busy, bus_a.out_valid, bus_a.err_out, bus_a.out_last,
                  bus_a.done, bus_a.err_found, bus_a.failed};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_start(input bit b, input logic s, input logic [15:0] sg, input logic [1:0] ec);
      if (b) begin
         bus_b.start = s; bus_b.sigma = sg; bus_b.err_count = ec;
      end else begin
         bus_a.start = s; bus_a.sigma = sg; bus_a.err_count = ec;
      end
   endtask

   task automatic set_ready(input bit b, input logic r);
      if (b) bus_b.out_ready = r; else bus_a.out_ready = r;
   endtask

   // Runs one codeword; entered and left at posedge+1 with the DUT idle.
   task automatic run_cw(input bit b, input logic [15:0] sg, input logic [1:0] ec,
                         input int stall_at, input int stall_len,
                         input bit mid_start, input bit rnd_ready);
      int n, k, cyc, stalls, held;
      logic rdy, v, prev_stall, prev_err;
      logic [2:0] dexp;
      n = b ? NB : NA;
      k = 0; cyc = 1; stalls = 0; held = 0;
      prev_stall = 1'b0; prev_err = 1'b0;
      push_expect(b, sg, ec, n, dexp);
      set_start(b, 1'b1, sg, ec);
      @(posedge clk); #1;
      set_start(b, 1'b0, 16'h0, 2'd0);
      check("first_beat_valid", get_valid(b), 1'b1);
      while (k < n && cyc < 300) begin
         v = get_valid(b);
         if (k == stall_at && held < stall_len) begin
            rdy = 1'b0;
            held++;
         end else if (rnd_ready) begin
            rdy = ($urandom_range(0, 3) != 0);
         end else begin
            rdy = 1'b1;
         end
         if (v && !rdy) stalls++;
         if (prev_stall) begin
            check("stall_valid_hold", v, 1'b1);
            check("stall_err_hold", get_err(b), prev_err);
         end
         prev_stall = !rdy;
         prev_err   = get_err(b);
         if (mid_start) set_start(b, !rdy, 16'h0891, 2'd2);
         set_ready(b, rdy);
         @(posedge clk); #1;
         if (v && rdy) k++;
         else if (!v) cyc = cyc + 0;
         cyc++;
      end
      set_start(b, 1'b0, 16'h0, 2'd0);
      set_ready(b, 1'b1);
      if (k < n) begin
         check("beat_budget", k, n);
         return;
      end
      check("done_cycle", cyc, n + 1 + stalls);
      check("done_pulse_busy", {get_done(b), get_busy(b), get_valid(b)}, 3'b110);
      @(posedge clk); #1;
      check("idle_after_done", {get_busy(b), get_done(b), get_valid(b)}, 3'b000);
      check("result_hold", get_res(b), dexp);
   endtask

   task automatic reset_mid;
      logic [2:0] dexp;
      int dcount;
      dcount = 0;
      push_expect(1'b0, 16'h0061, 2'd1, NA, dexp);
      set_ready(1'b0, 1'b1);
      set_start(1'b0, 1'b1, 16'h0061, 2'd1);
      @(posedge clk); #1;
      set_start(1'b0, 1'b0, 16'h0, 2'd0);
      repeat (6) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("reset_mid_outputs", get_all(1'b0), 8'h00);
      exp_a_q.delete();
      done_a_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (get_done(1'b0)) dcount++;
      end
      check("no_done_after_reset", dcount, 0);
      run_cw(1'b0, 16'h0001, 2'd0, -1, 0, 1'b0, 1'b0);
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      logic [1:0] e;
      logic [2:0] d;
      if (bus_a.out_valid && bus_a.out_ready) begin
         if (exp_a_q.size() == 0) check("beat_a_unexpected", 1, 0);
         else begin
            e = exp_a_q.pop_front();
            check("beat_a", {bus_a.err_out, bus_a.out_last}, e);
         end
      end
      if (bus_a.done) begin
         if (done_a_q.size() == 0) check("done_a_unexpected", 1, 0);
         else begin
            d = done_a_q.pop_front();
            check("done_a_result", {bus_a.err_found, bus_a.failed}, d);
         end
      end
   end

   always @(negedge clk) begin
      logic [1:0] e;
      logic [2:0] d;
      if (bus_b.out_valid && bus_b.out_ready) begin
         if (exp_b_q.size() == 0) check("beat_b_unexpected", 1, 0);
         else begin
            e = exp_b_q.pop_front();
            check("beat_b", {bus_b.err_out, bus_b.out_last}, e);
         end
      end
      if (bus_b.done) begin
         if (done_b_q.size() == 0) check("done_b_unexpected", 1, 0);
         else begin
            d = done_b_q.pop_front();
            check("done_b_result", {bus_b.err_found, bus_b.failed}, d);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int x;
      logic [15:0] sg;
      logic [1:0]  ec;
      x = 1;
      for (int i = 0; i < 15; i++) begin
         alog[i] = x;
         lg[x]   = i;
         x = x << 1;
         if ((x & 16) != 0) x = x ^ 'h13;
      end
      lg[0] = 0;

      rst_n = 1'b0;
      set_start(1'b0, 1'b0, 16'h0, 2'd0);
      set_start(1'b1, 1'b0, 16'h0, 2'd0);
      set_ready(1'b0, 1'b0);
      set_ready(1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs_a", get_all(1'b0), 8'h00);
      check("reset_outputs_b", get_all(1'b1), 8'h00);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single error at degree 5, then two errors, then a count mismatch.
      run_cw(1'b0, 16'h0061, 2'd1, -1, 0, 1'b0, 1'b0);
      run_cw(1'b0, 16'h0891, 2'd2, -1, 0, 1'b0, 1'b0);
      run_cw(1'b0, 16'h0061, 2'd2, -1, 0, 1'b0, 1'b0);
      // Backpressure at k=4 for 3 cycles with an ignored start meanwhile.
      run_cw(1'b0, 16'h0061, 2'd1, 4, 3, 1'b1, 1'b0);
      // sigma_0 == 0 and err_count == 0 corner cases.
      run_cw(1'b0, 16'h0000, 2'd0, -1, 0, 1'b0, 1'b0);
      run_cw(1'b0, 16'h0060, 2'd1, -1, 0, 1'b0, 1'b0);

      reset_mid();

      // Back-to-back random codewords with random backpressure.
      for (int i = 0; i < 25; i++) begin
         rand_cw(NA, sg, ec);
         run_cw(1'b0, sg, ec, -1, 0, 1'b0, 1'b1);
      end

      // Shortened code.
      run_cw(1'b1, 16'h0041, 2'd1, -1, 0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         rand_cw(NB, sg, ec);
         run_cw(1'b1, sg, ec, -1, 0, 1'b0, 1'b1);
      end

      repeat (5) @(posedge clk);
      #1;
      check("drain_a", exp_a_q.size() + done_a_q.size(), 0);
      check("drain_b", exp_b_q.size() + done_b_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
